// File: rtl/led_sft_drv.sv
// -----------------------------------------------------------------------------
// led_sft_drv
// Serial output stage for the LED controller. Shifts an DW-bit LED image into
// an external 74HC595-style shift register, then pulses its storage latch.
// One update arriving mid-frame is buffered and becomes the next frame, so the
// upstream controller never has to wait.
//
// Parameters
//   DW        image width in bits (shift pulses per frame)
//   DIV       clk cycles per shift-clock phase and per latch pulse (1..255)
//   MSB_FIRST 1: din[DW-1] leaves first, 0: din[0] leaves first
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   vld       in   one-cycle update strobe, din sampled with it
//   din       in   LED image
//   busy      out  high while a frame is shifted or latched
//   done      out  one-cycle pulse after a frame has been latched
//   sft_shcp  out  shift clock (external part samples sft_ds on rising edge)
//   sft_stcp  out  storage latch pulse
//   sft_ds    out  serial data
// -----------------------------------------------------------------------------
module led_sft_drv #(
   parameter int DW        = 8,
   parameter int DIV       = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vld,
   input  logic [DW-1:0] din,
   output logic          busy,
   output logic          done,
   output logic          sft_shcp,
   output logic          sft_stcp,
   output logic          sft_ds
);

   localparam int PW = $clog2(DIV + 1);
   localparam int BW = $clog2(DW + 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SLOW  = 2'd1,
      SHIGH = 2'd2,
      LATCH = 2'd3
   } state_t;

   state_t          state_reg, state_next;
   logic [PW-1:0]   phase_reg, phase_next;
   logic [BW-1:0]   bit_reg, bit_next;
   logic [DW-1:0]   sreg_reg, sreg_next;
   logic [DW-1:0]   pend_buf_reg, pend_buf_next;
   logic            pend_reg, pend_next;

   logic            busy_reg, busy_next;
   logic            done_reg, done_next;
   logic            shcp_reg, shcp_next;
   logic            stcp_reg, stcp_next;
   logic            ds_reg, ds_next;

   logic            phase_end;
   logic [DW-1:0]   sreg_shifted;
   logic            next_bit;

   assign phase_end = (phase_reg == PH_LAST);

   // Direction of travel through the shift register: the bit on sft_ds is
   // always taken from the end that is shifted out next.
   always_comb begin
      if (MSB_FIRST != 0) begin
         sreg_shifted = sreg_reg << 1;
      end else begin
         sreg_shifted = sreg_reg >> 1;
      end
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         phase_reg    <= '0;
         bit_reg      <= '0;
         sreg_reg     <= '0;
         pend_buf_reg <= '0;
         pend_reg     <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         shcp_reg     <= 1'b0;
         stcp_reg     <= 1'b0;
         ds_reg       <= 1'b0;
      end else begin
         state_reg    <= state_next;
         phase_reg    <= phase_next;
         bit_reg      <= bit_next;
         sreg_reg     <= sreg_next;
         pend_buf_reg <= pend_buf_next;
         pend_reg     <= pend_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         shcp_reg     <= shcp_next;
         stcp_reg     <= stcp_next;
         ds_reg       <= ds_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      phase_next    = phase_reg;
      bit_next      = bit_reg;
      sreg_next     = sreg_reg;
      pend_buf_next = pend_buf_reg;
      pend_next     = pend_reg;
      done_next     = 1'b0;

      // Any strobe while a frame is in flight lands in the pending buffer;
      // the last one before the frame ends wins.
      if ((state_reg != IDLE) && vld) begin
         pend_buf_next = din;
         pend_next     = 1'b1;
      end

      case (state_reg)
         IDLE: begin
            if (vld) begin
               sreg_next  = din;
               phase_next = '0;
               bit_next   = '0;
               state_next = SLOW;
            end
         end

         SLOW: begin
            if (phase_end) begin
               phase_next = '0;
               state_next = SHIGH;
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end

         SHIGH: begin
            if (phase_end) begin
               phase_next = '0;
               sreg_next  = sreg_shifted;
               bit_next   = bit_reg + 1'b1;
               state_next = (bit_reg == BIT_LAST) ? LATCH : SLOW;
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end

         LATCH: begin
            if (phase_end) begin
               done_next  = 1'b1;
               phase_next = '0;
               bit_next   = '0;
               // A strobe in the exit cycle counts as pending and, being the
               // newest, takes precedence over an older buffered value.
               if (vld) begin
                  sreg_next  = din;
                  pend_next  = 1'b0;
                  state_next = SLOW;
               end else if (pend_reg) begin
                  sreg_next  = pend_buf_reg;
                  pend_next  = 1'b0;
                  state_next = SLOW;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output decode. Decoded from the next state so that every pin is a flop
   // and lines up with the state it belongs to.
   // ------------------------------------------------------------------------
   always_comb begin
      next_bit  = (MSB_FIRST != 0) ? sreg_next[DW-1] : sreg_next[0];
      busy_next = (state_next != IDLE);
      shcp_next = (state_next == SHIGH);
      stcp_next = (state_next == LATCH);
      ds_next   = 1'b0;
      case (state_next)
         SLOW, SHIGH: ds_next = next_bit;
         LATCH:       ds_next = ds_reg;     // hold the last shifted bit
         default:     ds_next = 1'b0;
      endcase
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign sft_shcp = shcp_reg;
   assign sft_stcp = stcp_reg;
   assign sft_ds   = ds_reg;

endmodule

// File: tb/tb_led_sft_drv.sv
// -----------------------------------------------------------------------------
// tb_led_sft_drv
// Directed bench for led_sft_drv. One instance uses the default build
// (DW=8, DIV=4, MSB first); a second uses DIV=1, LSB first. Cycle 0 of each
// scenario is the cycle in which the first vld is driven.
// -----------------------------------------------------------------------------
module tb_led_sft_drv;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       vld, vld1;
   logic [7:0] din, din1;
   logic       busy, done, sft_shcp, sft_stcp, sft_ds;
   logic       busy1, done1, sft_shcp1, sft_stcp1, sft_ds1;

   always #5 clk = ~clk;

   led_sft_drv #(.DW(8), .DIV(4), .MSB_FIRST(1)) dut (
      .clk(clk), .rst_n(rst_n), .vld(vld), .din(din),
      .busy(busy), .done(done), .sft_shcp(sft_shcp),
      .sft_stcp(sft_stcp), .sft_ds(sft_ds)
   );

   led_sft_drv #(.DW(8), .DIV(1), .MSB_FIRST(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .vld(vld1), .din(din1),
      .busy(busy1), .done(done1), .sft_shcp(sft_shcp1),
      .sft_stcp(sft_stcp1), .sft_ds(sft_ds1)
   );

   int ncmp = 0;
   int nerr = 0;
   int cyc;

   // monitor state for dut
   logic shcp_prev;
   logic bits[$];
   int   edge_cyc[$];
   int   done_cyc[$];
   int   busy_cnt, busy_first, busy_last;
   int   stcp_cnt, stcp_first;
   // monitor state for dut1
   logic shcp1_prev;
   logic bits1[$];
   int   done1_cyc[$];
   int   busy1_cnt, busy1_first;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      cyc = 0;
      shcp_prev = sft_shcp;
      bits.delete(); edge_cyc.delete(); done_cyc.delete();
      busy_cnt = 0; busy_first = -1; busy_last = -1;
      stcp_cnt = 0; stcp_first = -1;
      shcp1_prev = sft_shcp1;
      bits1.delete(); done1_cyc.delete();
      busy1_cnt = 0; busy1_first = -1;
   endtask

   // Advance one clock and sample all outputs 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (sft_shcp && !shcp_prev) begin
         bits.push_back(sft_ds);
         edge_cyc.push_back(cyc);
      end
      shcp_prev = sft_shcp;
      if (done) done_cyc.push_back(cyc);
      if (busy) begin
         busy_cnt++;
         if (busy_first < 0) busy_first = cyc;
         busy_last = cyc;
      end
      if (sft_stcp) begin
         stcp_cnt++;
         if (stcp_first < 0) stcp_first = cyc;
      end
      if (sft_shcp1 && !shcp1_prev) bits1.push_back(sft_ds1);
      shcp1_prev = sft_shcp1;
      if (done1) done1_cyc.push_back(cyc);
      if (busy1) begin
         busy1_cnt++;
         if (busy1_first < 0) busy1_first = cyc;
      end
      $display("cyc=%0d vld=%b din=%h busy=%b done=%b shcp=%b stcp=%b ds=%b",
               cyc, vld, din, busy, done, sft_shcp, sft_stcp, sft_ds);
   endtask

   // Frame k as captured at the rising shift-clock edges, first bit as MSB.
   function automatic logic [7:0] word_msb(input int k);
      logic [7:0] w;
      w = '0;
      for (int i = 0; i < 8; i++)
         if (8 * k + i < bits.size()) w = {w[6:0], bits[8 * k + i]};
      return w;
   endfunction

   // dut1 frame, first bit as bit 0.
   function automatic logic [7:0] word1_lsb();
      logic [7:0] w;
      w = '0;
      for (int i = 0; i < 8; i++)
         if (i < bits1.size()) w[i] = bits1[i];
      return w;
   endfunction

   initial begin
      rst_n = 1'b0; vld = 1'b0; din = '0; vld1 = 1'b0; din1 = '0;
      cyc = 0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("reset_outs", {busy, done, sft_shcp, sft_stcp, sft_ds}, 5'b0);
      check("reset_outs1", {busy1, done1, sft_shcp1, sft_stcp1, sft_ds1}, 5'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_release", {busy, done, sft_shcp, sft_stcp, sft_ds}, 5'b0);

      // ---- single frame, A5 ----
      clear_mon();
      vld = 1'b1; din = 8'hA5;
      step();
      vld = 1'b0;
      while (cyc < 75) step();
      check("a5_nbits", bits.size(), 8);
      check("a5_word", word_msb(0), 8'hA5);
      check("a5_first_edge", edge_cyc.size() > 0 ? edge_cyc[0] : -1, 5);
      for (int i = 0; i + 1 < edge_cyc.size(); i++)
         check($sformatf("a5_edge_gap%0d", i), edge_cyc[i + 1] - edge_cyc[i], 8);
      check("a5_stcp_cnt", stcp_cnt, 4);
      check("a5_stcp_first", stcp_first, 65);
      check("a5_busy_first", busy_first, 1);
      check("a5_busy_last", busy_last, 68);
      check("a5_busy_cnt", busy_cnt, 68);
      check("a5_ndone", done_cyc.size(), 1);
      check("a5_done_cyc", done_cyc.size() > 0 ? done_cyc[0] : -1, 69);
      check("a5_idle_ds", {sft_ds, sft_shcp}, 2'b00);

      // ---- pending overwrite: 3C, FF, 81 ----
      clear_mon();
      vld = 1'b1; din = 8'h3C;
      while (cyc < 145) begin
         step();
         vld = (cyc == 10) || (cyc == 20);
         din = (cyc == 10) ? 8'hFF : 8'h81;
      end
      vld = 1'b0;
      check("pend_nbits", bits.size(), 16);
      check("pend_word0", word_msb(0), 8'h3C);
      check("pend_word1", word_msb(1), 8'h81);
      check("pend_ndone", done_cyc.size(), 2);
      check("pend_done0", done_cyc.size() > 0 ? done_cyc[0] : -1, 69);
      check("pend_done1", done_cyc.size() > 1 ? done_cyc[1] : -1, 137);
      check("pend_busy_cnt", busy_cnt, 136);
      check("pend_busy_span", busy_last - busy_first + 1, 136);

      // ---- vld exactly in the LATCH exit cycle ----
      clear_mon();
      vld = 1'b1; din = 8'hC3;
      while (cyc < 145) begin
         step();
         vld = (cyc == 68);
         din = (cyc == 68) ? 8'h0F : 8'h00;
      end
      vld = 1'b0;
      check("exit_word0", word_msb(0), 8'hC3);
      check("exit_word1", word_msb(1), 8'h0F);
      check("exit_ndone", done_cyc.size(), 2);
      check("exit_done_gap", done_cyc.size() > 1 ? done_cyc[1] - done_cyc[0] : -1, 68);
      check("exit_busy_cnt", busy_cnt, 136);
      check("exit_busy_span", busy_last - busy_first + 1, 136);

      // ---- reset mid-frame ----
      clear_mon();
      vld = 1'b1; din = 8'hAA;
      step();
      vld = 1'b0;
      while (cyc < 30) step();
      check("rst_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_outs_now", {busy, done, sft_shcp, sft_stcp, sft_ds}, 5'b0);
      repeat (3) step();
      rst_n = 1'b1;
      while (cyc < 80) step();
      check("rst_no_stcp", stcp_cnt, 0);
      check("rst_no_done", done_cyc.size(), 0);
      clear_mon();
      vld = 1'b1; din = 8'h55;
      step();
      vld = 1'b0;
      while (cyc < 75) step();
      check("rst_word", word_msb(0), 8'h55);
      check("rst_nbits", bits.size(), 8);
      check("rst_busy_cnt", busy_cnt, 68);
      check("rst_busy_first", busy_first, 1);
      check("rst_done_cyc", done_cyc.size() > 0 ? done_cyc[0] : -1, 69);
      check("rst_stcp_cnt", stcp_cnt, 4);

      // ---- LSB first, DIV=1 ----
      clear_mon();
      vld1 = 1'b1; din1 = 8'h01;
      step();
      vld1 = 1'b0;
      while (cyc < 25) step();
      check("lsb_nbits", bits1.size(), 8);
      check("lsb_first_bit", bits1.size() > 0 ? bits1[0] : 1'bx, 1'b1);
      check("lsb_word", word1_lsb(), 8'h01);
      check("lsb_busy_cnt", busy1_cnt, 17);
      check("lsb_busy_first", busy1_first, 1);
      check("lsb_done_cyc", done1_cyc.size() > 0 ? done1_cyc[0] : -1, 18);

      // ---- vld held high for 200 cycles, din = cycle + 16 ----
      clear_mon();
      vld = 1'b1; din = 8'h10;
      while (cyc < 285) begin
         step();
         vld = (cyc < 200);
         din = 8'(cyc + 16);
      end
      vld = 1'b0;
      check("cont_ndone", done_cyc.size(), 4);
      check("cont_nbits", bits.size(), 32);
      check("cont_word0", word_msb(0), 8'h10);
      check("cont_word1", word_msb(1), 8'h54);
      check("cont_word2", word_msb(2), 8'h98);
      check("cont_word3", word_msb(3), 8'hD7);
      check("cont_busy_cnt", busy_cnt, 272);
      check("cont_busy_span", busy_last - busy_first + 1, 272);
      check("cont_done_last", done_cyc.size() > 3 ? done_cyc[3] : -1, 273);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/led_sft_drv.md
Name: led_sft_drv

Overview:
- Serial output stage for the LED controller. Takes the 8-bit LED image register plus its update strobe and shifts the image into an external 74HC595-style shift register.
- Drives the shift clock (sft_shcp), serial data (sft_ds) and storage latch (sft_stcp) at a programmable bit rate.
- Buffers one pending update that arrives mid-frame, so the upstream controller never needs to stall.

Parameters:
- DW, 8, image width in bits (number of shift pulses per frame).
- DIV, 4, length in clk cycles of each shift-clock phase (low or high) and of the latch pulse; legal range 1..255.
- MSB_FIRST, 1, 1 shifts din[DW-1] first; 0 shifts din[0] first.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- vld  in  1  one-cycle update strobe; din is sampled on that cycle.
- din  in  DW  LED image to be displayed.
- busy  out  1  high while a frame is being shifted or latched.
- done  out  1  one-cycle pulse when a frame has been latched.
- sft_shcp  out  1  shift-register clock; external part samples sft_ds on its rising edge.
- sft_stcp  out  1  storage-register latch pulse.
- sft_ds  out  1  serial data.

Behaviour:
- Reset (asynchronous assertion, synchronous release):
  - Outputs busy, done, sft_shcp, sft_stcp and sft_ds all 0.
  - FSM goes to IDLE; shift register, pending buffer and pending flag are cleared.
  - Reset mid-frame aborts the frame immediately with no latch pulse.
- FSM states: IDLE, SLOW, SHIGH, LATCH.
  - A phase counter (clog2(DIV+1) bits) counts DIV cycles per state.
  - A bit counter (clog2(DW+1) bits) counts shifted bits.
- IDLE:
  - On vld=1: load din into the shift register and go to SLOW, with phase counter = 0 and bit counter = 0.
  - busy rises in the next cycle.
- SLOW:
  - sft_shcp = 0; sft_ds = current output bit (MSB or LSB per MSB_FIRST).
  - After DIV cycles, go to SHIGH.
- SHIGH:
  - sft_shcp = 1; sft_ds held stable through the whole phase, giving DIV cycles of hold after the rising edge.
  - After DIV cycles:
    - Shift the register by one and increment the bit counter.
    - If the bit counter reaches DW, go to LATCH; otherwise go to SLOW.
- LATCH:
  - sft_shcp = 0, sft_stcp = 1 for DIV cycles; sft_ds holds its last value.
  - On exit, assert done for exactly one cycle, registered and coincident with the first cycle of the next state.
- Frame timing:
  - busy is high for exactly (2*DW+1)*DIV consecutive cycles per frame.
  - Default (DW=8, DIV=4): 68 cycles.
  - With vld at cycle 0: busy is high in cycles 1..68 and done is high in cycle 69.
- Pending buffer:
  - vld while busy=1 writes din into the pending buffer and sets the pending flag.
  - Further vld strobes overwrite the buffer (last write wins); the frame in flight is never modified.
- Frame completion with pending set:
  - Load the pending buffer, clear the flag and go directly to SLOW; no IDLE cycle is inserted.
  - busy stays high continuously and done still pulses for that cycle.
- vld in the same cycle as LATCH exit:
  - Treated as pending, so its data is used for the immediately following frame.
  - If a pending value was already present, the new value overwrites it.
- All outputs are registered (no combinational path from vld/din to the pins).
- sft_ds is 0 in IDLE.
- Counters wrap only by explicit reset to 0 at phase and frame boundaries; there are no free-running counters.

Test Plan:
- Reset, then vld with din=8'hA5 (DIV=4, MSB_FIRST=1):
  - sft_ds sampled at the 8 sft_shcp rising edges reads 1,0,1,0,0,1,0,1.
  - Adjacent rising edges are 8 cycles apart.
  - sft_stcp is high for 4 cycles after the 8th pulse.
  - busy is high for cycles 1..68; done is high only in cycle 69.
- vld with 8'h3C at cycle 0, vld with 8'hFF at cycle 10, vld with 8'h81 at cycle 20:
  - Frame 1 shifts 3C; done pulses at cycle 69.
  - Frame 2 starts in cycle 69 with busy held high and shifts 81.
  - 8'hFF is never output.
- vld with 8'h0F exactly in the cycle LATCH exits:
  - A second frame carrying 0F follows back-to-back.
  - Exactly two done pulses occur, 68 cycles apart.
- rst_n driven low at cycle 30 of a frame:
  - All outputs are 0 within the same cycle; no sft_stcp pulse occurs.
  - After release, a vld with 8'h55 produces a clean 68-cycle frame.
- MSB_FIRST=0, DIV=1, din=8'h01:
  - The first sft_ds bit is 1 and the remaining seven are 0.
  - busy is high for 17 cycles.
- vld held continuously high for 200 cycles with incrementing din:
  - Frames run back-to-back with no gaps.
  - Each frame outputs the din value present in the final cycle that vld was sampled while the previous frame was busy.
  - The done count equals the number of frames.
